// File: rtl/twdl_stage_sched.sv
// Per-stage scheduler for the mixed-radix twiddle stage: latches a frame config, gates 5-lane beats
// (s_rdy high only in RUN, tw_in_val same cycle as accept) and holds done off until the twiddle pipe drains.
module twdl_stage_sched #(
  parameter int wCnt      = 12,
  parameter int DRAIN_CYC = 26,
  parameter int BYP_DRAIN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      cfg_factor,
  input  logic [wCnt-1:0] cfg_len,
  input  logic [wCnt-1:0] cfg_bfly,
  input  logic [wCnt-1:0] cfg_blocks,
  input  logic            s_val,
  output logic            s_rdy,
  output logic            tw_in_val,
  output logic [wCnt-1:0] twdl_numrtr_1,
  output logic [wCnt-1:0] twdl_demontr,
  output logic [2:0]      factor,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [wCnt-1:0] ONE     = wCnt'(1);
  localparam logic [wCnt-1:0] LEN_BYP = wCnt'(3);
  localparam logic [wCnt-1:0] DRN_N   = wCnt'(DRAIN_CYC - 1);
  localparam logic [wCnt-1:0] DRN_BYP = wCnt'(BYP_DRAIN - 1);

  logic [1:0]      r_state;
  logic [2:0]      r_fac_h;
  logic [wCnt-1:0] r_len_h;
  logic [wCnt-1:0] r_bfly_h;
  logic [wCnt-1:0] r_blk_h;
  logic [wCnt-1:0] r_bf_cnt;
  logic [wCnt-1:0] r_blk_cnt;
  logic [wCnt-1:0] r_drain_cnt;
  logic            r_s_rdy;
  logic            r_err;
  logic [wCnt-1:0] r_demontr;
  logic [2:0]      r_factor;

  logic [wCnt+2:0] w_prod;
  logic            w_cfg_ok;
  logic            w_accept;
  logic            w_bf_last;
  logic            w_blk_last;

  // wCnt+3 bits holds any wCnt x 3-bit product, so the equality test never aliases
  assign w_prod     = (wCnt+3)'(cfg_bfly) * (wCnt+3)'(cfg_factor);
  assign w_cfg_ok   = (cfg_factor >= 3'd2) && (cfg_factor <= 3'd5) &&
                      (|cfg_bfly) && (|cfg_blocks) && (|cfg_len) &&
                      (w_prod == {3'b000, cfg_len});
  assign w_accept   = s_val & r_s_rdy;
  assign w_bf_last  = (r_bf_cnt == r_bfly_h - ONE);
  assign w_blk_last = (r_blk_cnt == r_blk_h - ONE);

  assign s_rdy         = r_s_rdy;
  assign tw_in_val     = w_accept;
  assign twdl_numrtr_1 = r_bf_cnt;
  assign twdl_demontr  = r_demontr;
  assign factor        = r_factor;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DRAIN) && (r_drain_cnt == '0);
  assign err           = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_fac_h     <= '0;
      r_len_h     <= '0;
      r_bfly_h    <= '0;
      r_blk_h     <= '0;
      r_bf_cnt    <= '0;
      r_blk_cnt   <= '0;
      r_drain_cnt <= '0;
      r_s_rdy     <= 1'b0;
      r_err       <= 1'b0;
      r_demontr   <= '0;
      r_factor    <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_fac_h  <= cfg_factor;
              r_len_h  <= cfg_len;
              r_bfly_h <= cfg_bfly;
              r_blk_h  <= cfg_blocks;
              r_state  <= S_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_demontr <= r_len_h;
          r_factor  <= r_fac_h;
          r_bf_cnt  <= '0;
          r_blk_cnt <= '0;
          r_s_rdy   <= 1'b1;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_bf_last) begin
              r_bf_cnt  <= '0;
              r_blk_cnt <= r_blk_cnt + ONE;
              if (w_blk_last) begin
                r_s_rdy     <= 1'b0;
                r_drain_cnt <= (r_len_h == LEN_BYP) ? DRN_BYP : DRN_N;
                r_state     <= S_DRAIN;
              end
            end else begin
              r_bf_cnt <= r_bf_cnt + ONE;
            end
          end
        end
        default: begin
          if (r_drain_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt - ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twdl_stage_sched.sv
// Directed bench for twdl_stage_sched: expected numerators are queued per frame and popped on each accept.
module tb_twdl_stage_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  cfg_factor;
  logic [11:0] cfg_len;
  logic [11:0] cfg_bfly;
  logic [11:0] cfg_blocks;
  logic        s_val;
  logic        s_rdy;
  logic        tw_in_val;
  logic [11:0] twdl_numrtr_1;
  logic [11:0] twdl_demontr;
  logic [2:0]  factor;
  logic        busy;
  logic        done;
  logic        err;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int exp_q[$];

  twdl_stage_sched #(.wCnt(12), .DRAIN_CYC(26), .BYP_DRAIN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_factor(cfg_factor),
    .cfg_len(cfg_len), .cfg_bfly(cfg_bfly), .cfg_blocks(cfg_blocks),
    .s_val(s_val), .s_rdy(s_rdy), .tw_in_val(tw_in_val),
    .twdl_numrtr_1(twdl_numrtr_1), .twdl_demontr(twdl_demontr),
    .factor(factor), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_rdy"}, s_rdy, 0);
    chk({tag, "_tw_in_val"}, tw_in_val, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_numrtr"}, twdl_numrtr_1, 0);
    chk({tag, "_demontr"}, twdl_demontr, 0);
    chk({tag, "_factor"}, factor, 0);
  endtask

  task automatic bad_cfg(input string tag, input logic [2:0] f, input logic [11:0] len,
                         input logic [11:0] bfly, input logic [11:0] blks);
    cfg_factor = f; cfg_len = len; cfg_bfly = bfly; cfg_blocks = blks; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_err_pulse"}, err, 1);
    chk({tag, "_busy"}, busy, 0);
    tick();
    @(negedge clk);
    chk({tag, "_err_clear"}, err, 0);
    chk({tag, "_still_idle"}, busy, 0);
  endtask

  // toggle: s_val alternates; inj: start pulses during RUN and on done; rst_after: reset after that many accepts
  task automatic run_frame(input string tag, input logic [2:0] f, input logic [11:0] len,
                           input logic [11:0] bfly, input logic [11:0] blks,
                           input int toggle, input int inj, input int rst_after, input int exp_drain);
    int acc, last_acc, rdy_cyc, errs, seen_done, bad;
    bit fin;
    for (int b = 0; b < int'(blks); b++)
      for (int k = 0; k < int'(bfly); k++)
        exp_q.push_back(k);
    cfg_factor = f; cfg_len = len; cfg_bfly = bfly; cfg_blocks = blks;
    s_val = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    acc = 0; last_acc = -1000; rdy_cyc = 0; errs = 0; fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      cfg_factor = 3'($urandom); cfg_len = 12'($urandom);
      cfg_bfly = 12'($urandom); cfg_blocks = 12'($urandom);
      s_val = (toggle != 0) ? (c % 2 == 0) : 1'b1;
      start = 1'b0;
      if (inj != 0 && acc == 3) start = 1'b1;
      if (inj != 0 && cyc == last_acc + exp_drain) start = 1'b1;
      @(negedge clk);
      if (tw_in_val) begin
        if (exp_q.size() == 0) chk({tag, "_extra_accept"}, 1, 0);
        else chk({tag, "_numrtr"}, twdl_numrtr_1, exp_q.pop_front());
        chk({tag, "_demontr"}, twdl_demontr, len);
        chk({tag, "_factor"}, factor, f);
        acc++;
        last_acc = cyc;
      end else if (s_rdy && exp_q.size() > 0) begin
        chk({tag, "_numrtr_hold"}, twdl_numrtr_1, exp_q[0]);
      end
      if (s_rdy) rdy_cyc++;
      if (err) errs++;
      if (done) begin
        fin = 1'b1;
        chk({tag, "_done_delay"}, cyc - last_acc, exp_drain);
      end
      if (rst_after > 0 && acc == rst_after) begin
        tick();
        start = 1'b0; s_val = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        tick();
        rst_n = 1'b1; s_val = 1'b1;
        @(negedge clk);
        check_all_zero({tag, "_post_rst"});
        seen_done = 0; bad = 0;
        for (int w = 0; w < 40; w++) begin
          tick();
          @(negedge clk);
          if (done) seen_done++;
          if (busy || tw_in_val) bad++;
        end
        chk({tag, "_no_done_after_rst"}, seen_done, 0);
        chk({tag, "_idle_after_rst"}, bad, 0);
        exp_q.delete();
        s_val = 1'b0;
        return;
      end
      if (!fin) tick();
    end
    if (!fin) chk({tag, "_done_timeout"}, 0, 1);
    chk({tag, "_accepts"}, acc, int'(bfly) * int'(blks));
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_no_err"}, errs, 0);
    if (toggle == 0) chk({tag, "_rdy_cycles"}, rdy_cyc, int'(bfly) * int'(blks));
    exp_q.delete();
    tick();
    start = 1'b0; s_val = 1'b0;
    if (inj != 0) begin
      cfg_factor = 3'd2; cfg_len = 12'd2; cfg_bfly = 12'd1; cfg_blocks = 12'd1; start = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_busy_after_done"}, busy, 0);
    chk({tag, "_single_done"}, done, 0);
    if (inj != 0) begin
      tick();
      start = 1'b0; s_val = 1'b1;
      @(negedge clk);
      chk({tag, "_restart_accepted"}, busy, 1);
      fin = 1'b0;
      for (int w = 0; w < 100 && !fin; w++) begin
        tick();
        @(negedge clk);
        if (done) fin = 1'b1;
      end
      chk({tag, "_restart_done"}, fin, 1);
      tick();
      s_val = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_val = 1'b0;
    cfg_factor = '0; cfg_len = '0; cfg_bfly = '0; cfg_blocks = '0;
    tick();
    tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    run_frame("r2_stuck", 3'd2, 12'd8, 12'd4, 12'd2, 0, 0, 0, 26);
    run_frame("r5_toggle", 3'd5, 12'd20, 12'd4, 12'd3, 1, 0, 0, 26);
    run_frame("bypass", 3'd3, 12'd3, 12'd1, 12'd4, 0, 0, 0, 1);
    bad_cfg("bad_radix6", 3'd6, 12'd12, 12'd2, 12'd1);
    bad_cfg("bad_product", 3'd4, 12'd12, 12'd4, 12'd1);
    run_frame("start_ignored", 3'd2, 12'd8, 12'd4, 12'd2, 0, 1, 0, 26);
    run_frame("mid_reset", 3'd4, 12'd16, 12'd4, 12'd4, 0, 0, 5, 26);
    run_frame("after_reset", 3'd4, 12'd16, 12'd4, 12'd4, 0, 0, 0, 26);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
